// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline control bundle between the 5-stage datapath and the hazard sequencer.
// The master side is the datapath (hazard sources, consumes enables/kills); the slave side is the sequencer.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       ifid_rs1;
   logic [4:0]       ifid_rs2;
   logic             ifid_use_rs1;
   logic             ifid_use_rs2;
   logic             idex_memread;
   logic [4:0]       idex_destreg;
   logic             exmem_memread;
   logic             exmem_memwrite;
   logic             redirect;
   logic             dmem_ready;

   logic             dmem_req;
   logic             pc_we;
   logic             ifid_we;
   logic             idex_we;
   logic             exmem_we;
   logic             memwb_we;
   logic             ifid_kill;
   logic             idex_kill;
   logic             exmem_kill;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;
   logic [CNT_W-1:0] flush_count;

   modport master (
      output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
             idex_memread, idex_destreg, exmem_memread, exmem_memwrite,
             redirect, dmem_ready,
      input  dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_kill, idex_kill, exmem_kill, mem_timeout,
             stall_count, flush_count
   );

   modport slave (
      input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
             idex_memread, idex_destreg, exmem_memread, exmem_memwrite,
             redirect, dmem_ready,
      output dmem_req, pc_we, ifid_we, idex_we, exmem_we, memwb_we,
             ifid_kill, idex_kill, exmem_kill, mem_timeout,
             stall_count, flush_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: freezes on slow data-memory access, flushes on MEM-stage redirects,
// inserts one bubble on load-use, traps on memory timeout and keeps saturating stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned TO_W        = 8,
   parameter int unsigned CNT_W       = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.slave hz
);

   localparam logic [TO_W-1:0]  TIMEOUT = TO_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_FLUSH    = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ERROR    = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [TO_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   logic memop, mem_busy, rs1_hit, rs2_hit, lu_hazard;
   logic dmem_req_c, pc_we_c, ifid_we_c, idex_we_c, exmem_we_c, memwb_we_c;
   logic ifid_kill_c, idex_kill_c, exmem_kill_c;

   assign memop     = hz.exmem_memread | hz.exmem_memwrite;
   assign rs1_hit   = hz.ifid_use_rs1 & (hz.ifid_rs1 == hz.idex_destreg);
   assign rs2_hit   = hz.ifid_use_rs2 & (hz.ifid_rs2 == hz.idex_destreg);
   assign lu_hazard = hz.idex_memread & (hz.idex_destreg != 5'd0) & (rs1_hit | rs2_hit);
   // An access already stalled in MEM_WAIT stays busy regardless of the current memop lines
   assign mem_busy  = (state_q == ST_MEM_WAIT) | memop;

   // Next-state, counter update and pre-reset-gating control outputs
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      stall_d      = stall_q;
      flush_d      = flush_q;
      dmem_req_c   = 1'b0;
      pc_we_c      = 1'b0;
      ifid_we_c    = 1'b0;
      idex_we_c    = 1'b0;
      exmem_we_c   = 1'b0;
      memwb_we_c   = 1'b0;
      ifid_kill_c  = 1'b0;
      idex_kill_c  = 1'b0;
      exmem_kill_c = 1'b0;

      case (state_q)
         ST_RUN, ST_FLUSH, ST_MEM_WAIT: begin
            dmem_req_c = mem_busy;
            if (mem_busy && !hz.dmem_ready) begin
               if (state_q == ST_MEM_WAIT) begin
                  wait_d = wait_q + TO_W'(1);
                  if (wait_d >= TIMEOUT) begin
                     state_d = ST_ERROR;
                  end
               end else begin
                  wait_d  = TO_W'(1);
                  state_d = ST_MEM_WAIT;
               end
            end else if (hz.redirect) begin
               pc_we_c      = 1'b1;
               ifid_we_c    = 1'b1;
               idex_we_c    = 1'b1;
               exmem_we_c   = 1'b1;
               memwb_we_c   = 1'b1;
               ifid_kill_c  = 1'b1;
               idex_kill_c  = 1'b1;
               exmem_kill_c = 1'b1;
               wait_d       = '0;
               state_d      = ST_FLUSH;
               flush_d      = (flush_q == CNT_MAX) ? flush_q : flush_q + CNT_W'(1);
            end else if (lu_hazard && (state_q != ST_FLUSH)) begin
               // Hold PC and IFID, let the load move on and bubble EX
               idex_we_c   = 1'b1;
               exmem_we_c  = 1'b1;
               memwb_we_c  = 1'b1;
               idex_kill_c = 1'b1;
               wait_d      = '0;
               state_d     = ST_RUN;
            end else begin
               pc_we_c    = 1'b1;
               ifid_we_c  = 1'b1;
               idex_we_c  = 1'b1;
               exmem_we_c = 1'b1;
               memwb_we_c = 1'b1;
               wait_d     = '0;
               state_d    = ST_RUN;
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d = ST_RUN;
            wait_d  = '0;
         end
      endcase

      if (!pc_we_c && (state_q != ST_ERROR)) begin
         stall_d = (stall_q == CNT_MAX) ? stall_q : stall_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   // Reset forces every enable, kill and request low immediately
   assign hz.dmem_req    = rst & dmem_req_c;
   assign hz.pc_we       = rst & pc_we_c;
   assign hz.ifid_we     = rst & ifid_we_c;
   assign hz.idex_we     = rst & idex_we_c;
   assign hz.exmem_we    = rst & exmem_we_c;
   assign hz.memwb_we    = rst & memwb_we_c;
   assign hz.ifid_kill   = rst & ifid_kill_c;
   assign hz.idex_kill   = rst & idex_kill_c;
   assign hz.exmem_kill  = rst & exmem_kill_c;
   assign hz.mem_timeout = rst & (state_q == ST_ERROR);
   assign hz.stall_count = stall_q;
   assign hz.flush_count = flush_q;

   // A killed EXMEM entry must always be written, otherwise the kill is lost
   a_kill_writes: assert property (@(posedge clk) disable iff (!rst)
      hz.exmem_kill |-> hz.exmem_we);

endmodule
